weight_cache: RTL and testbench



---
 rtl/weight_cache_if.sv | 33 +++
 rtl/weight_cache.sv | 147 ++++++++++++++
 tb/tb_weight_cache.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/weight_cache_if.sv
// Host/consumer-facing bundle of the weight cache: job control, sizing, load stream and replay stream.
// The cache itself takes the slave view; whoever drives jobs and consumes words takes the master view.
interface weight_cache_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  start;
    logic [15:0]           Matrix_Row;
    logic [15:0]           Matrix_Col;
    logic [25:0]           OutMatrix_Row;
    logic                  busy;

    logic                  sData_valid;
    logic                  sData_ready;
    logic [DATA_WIDTH-1:0] sData_payload;

    logic                  Raddr_Valid;
    logic [DATA_WIDTH-1:0] mData;
    logic                  mValid;
    logic                  mReady;
    logic                  mLast;

    modport master (
        output start, Matrix_Row, Matrix_Col, OutMatrix_Row,
        output sData_valid, sData_payload, Raddr_Valid, mReady,
        input  busy, sData_ready, mData, mValid, mLast
    );

    modport slave (
        input  start, Matrix_Row, Matrix_Col, OutMatrix_Row,
        input  sData_valid, sData_payload, Raddr_Valid, mReady,
        output busy, sData_ready, mData, mValid, mLast
    );
endinterface

// File: rtl/weight_cache.sv
// Weight buffer: loads one int8 weight matrix as 64-bit words, then replays it OutMatrix_Row times
// through a single registered output stage, so each layer's weights are fetched externally only once.
module weight_cache #(
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 32768,
    parameter int ADDR_WIDTH = 15
) (
    input  logic           clk,
    input  logic           reset,
    weight_cache_if.slave  bus
);
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;
    logic [25:0]           reps_q, reps_d;
    logic [25:0]           rep_q, rep_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  remaining_q, remaining_d;
    logic                  mvalid_q, mvalid_d;
    logic                  mlast_q, mlast_d;
    logic [DATA_WIDTH-1:0] mdata_q;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [31:0]           product;
    logic [CNT_WIDTH-1:0]  words_new;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  last_rep;
    logic                  wr_en;
    logic                  rd_en;
    logic                  out_hs;

    assign product   = 32'(bus.Matrix_Row) * 32'(bus.Matrix_Col);
    assign words_new = CNT_WIDTH'(product >> 3);
    assign last_addr = ADDR_WIDTH'(words_q - 1'b1);
    assign last_rep  = (rep_q == reps_q - 26'd1);

    assign wr_en  = (state_q == LOAD) && bus.sData_valid;
    // A read may only be issued when the output register is empty or being drained this cycle.
    assign rd_en  = (state_q == SEND) && bus.Raddr_Valid && remaining_q && (!mvalid_q || bus.mReady);
    assign out_hs = mvalid_q && bus.mReady;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
        state_d     = state_q;
        words_d     = words_q;
        reps_d      = reps_q;
        rep_d       = rep_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        mvalid_d    = mvalid_q;
        mlast_d     = mlast_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    words_d = words_new;
                    reps_d  = bus.OutMatrix_Row;
                    if (words_new != '0 && bus.OutMatrix_Row != '0) begin
                        state_d   = LOAD;
                        wr_addr_d = '0;
                    end
                end
            end
            LOAD: begin
                if (wr_en) begin
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == last_addr) begin
                        state_d     = SEND;
                        rd_addr_d   = '0;
                        rep_d       = '0;
                        remaining_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (out_hs && mlast_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_en) begin
            mvalid_d = 1'b1;
            mlast_d  = (rd_addr_q == last_addr) && last_rep;
            if (rd_addr_q == last_addr) begin
                rd_addr_d = '0;
                rep_d     = rep_q + 26'd1;
                if (last_rep) begin
                    remaining_d = 1'b0;
                end
            end else begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end else if (out_hs) begin
            mvalid_d = 1'b0;
            mlast_d  = 1'b0;
        end
    end

    // NOTE: the weight RAM has no reset; its contents are don't-care until written, and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr_q] <= bus.sData_payload;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            words_q     <= '0;
            reps_q      <= '0;
            rep_q       <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            remaining_q <= 1'b0;
            mvalid_q    <= 1'b0;
            mlast_q     <= 1'b0;
            mdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            reps_q      <= reps_d;
            rep_q       <= rep_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            mvalid_q    <= mvalid_d;
            mlast_q     <= mlast_d;
            if (rd_en) begin
                mdata_q <= mem_q[rd_addr_q];
            end
        end
    end

    assign bus.sData_ready = (state_q == LOAD);
    assign bus.busy        = (state_q != IDLE);
    assign bus.mValid      = mvalid_q;
    assign bus.mLast       = mlast_q;
    assign bus.mData       = mdata_q;
endmodule

// File: tb/tb_weight_cache.sv
// Directed bench for weight_cache: load/replay order, mLast placement, backpressure hold,
// ignored start pulses, degenerate sizes and reset in the middle of a replay.
module tb_weight_cache;
    localparam int DW    = 64;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    weight_cache_if #(.DATA_WIDTH(DW)) bus ();

    weight_cache #(
        .DATA_WIDTH(DW),
        .MEM_DEPTH (DEPTH),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wdata(input logic [63:0] seed, input int i);
        return seed + 64'(i);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   bus.busy,        1'b0);
        check({tag, "_ready"},  bus.sData_ready, 1'b0);
        check({tag, "_mvalid"}, bus.mValid,      1'b0);
        check({tag, "_mlast"},  bus.mLast,       1'b0);
    endtask

    // One full job, driven and checked from the falling edge. abort_at >= 0 asserts reset once
    // that many words have been received and checks that every output clears at once.
    task automatic run_job(input int rows, input int cols, input int reps, input logic [63:0] seed,
                           input bit bp, input bit poke, input int abort_at);
        int          words;
        int          total;
        int          in_idx;
        int          out_idx;
        int          cyc;
        bit          stall;
        logic [63:0] held;
        words   = rows * cols / 8;
        total   = words * reps;
        in_idx  = 0;
        out_idx = 0;
        cyc     = 0;
        stall   = 1'b0;
        held    = '0;

        @(negedge clk);
        bus.Matrix_Row    = 16'(rows);
        bus.Matrix_Col    = 16'(cols);
        bus.OutMatrix_Row = 26'(reps);
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start         = 1'b0;
        bus.Matrix_Row    = '0;
        bus.Matrix_Col    = '0;
        bus.OutMatrix_Row = '0;
        check("ready_after_start", bus.sData_ready, 1'b1);

        while (out_idx < total && cyc < 20000) begin
            if (abort_at >= 0 && out_idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                check("abort_mdata", bus.mData, 64'h0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (stall) begin
                check("hold_mvalid", bus.mValid, 1'b1);
                check("hold_mdata",  bus.mData,  held);
            end
            bus.sData_valid   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.sData_payload = wdata(seed, in_idx);
            bus.mReady        = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.Raddr_Valid   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && (cyc == 2 || cyc == words + 6)) begin
                bus.start         = 1'b1;
                bus.Matrix_Row    = 16'd8;
                bus.Matrix_Col    = 16'd8;
                bus.OutMatrix_Row = 26'd1;
            end else begin
                bus.start         = 1'b0;
                bus.Matrix_Row    = '0;
                bus.Matrix_Col    = '0;
                bus.OutMatrix_Row = '0;
            end
            if (bus.sData_valid && bus.sData_ready) begin
                in_idx++;
            end
            if (bus.mValid && bus.mReady) begin
                check("mdata", bus.mData, wdata(seed, out_idx % words));
                check("mlast", bus.mLast, 1'(out_idx == total - 1));
                out_idx++;
            end else if (bus.mValid) begin
                check("mlast_idle", bus.mLast, 1'(out_idx == total - 1));
            end
            stall = bus.mValid && !bus.mReady;
            held  = bus.mData;
            @(negedge clk);
            cyc++;
        end

        bus.start       = 1'b0;
        bus.sData_valid = 1'b0;
        bus.mReady      = 1'b1;
        bus.Raddr_Valid = 1'b1;
        check("words_received", 64'(out_idx), 64'(total));
        check("words_accepted", 64'(in_idx),  64'(words));
        if (!bp) begin
            check("job_cycles", 64'(cyc), 64'(words * (reps + 1) + 1));
        end
        check_idle_outputs("job_end");
    endtask

    task automatic degenerate(input int rows, input int cols, input int reps, input string tag);
        @(negedge clk);
        bus.Matrix_Row    = 16'(rows);
        bus.Matrix_Col    = 16'(cols);
        bus.OutMatrix_Row = 26'(reps);
        bus.start         = 1'b1;
        bus.sData_valid   = 1'b1;
        @(negedge clk);
        bus.start         = 1'b0;
        repeat (3) begin
            check({tag, "_busy"},  bus.busy,        1'b0);
            check({tag, "_ready"}, bus.sData_ready, 1'b0);
            @(negedge clk);
        end
        bus.sData_valid = 1'b0;
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.Matrix_Row    = '0;
        bus.Matrix_Col    = '0;
        bus.OutMatrix_Row = '0;
        bus.sData_valid   = 1'b0;
        bus.sData_payload = '0;
        bus.Raddr_Valid   = 1'b1;
        bus.mReady        = 1'b1;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_mdata", bus.mData, 64'h0);
        rst_n = 1'b1;

        run_job(8, 8, 3, 64'h0, 1'b0, 1'b0, -1);
        run_job(8, 8, 2, 64'h1111_0000_0000_0000, 1'b0, 1'b1, -1);
        run_job(64, 32, 3, 64'hA5A5_0000_0000_1000, 1'b1, 1'b0, -1);
        run_job(16, 8, 4, 64'h3C3C_0000_0000_2000, 1'b1, 1'b1, -1);

        degenerate(8, 8, 0, "zero_reps");
        degenerate(0, 32, 5, "zero_rows");

        run_job(8, 16, 4, 64'h7777_0000_0000_3000, 1'b0, 1'b0, 32);
        check_idle_outputs("after_abort");
        run_job(8, 8, 2, 64'h0F0F_0000_0000_4000, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
